// File: rtl/weight_tap_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_tap_loader_if
// Description : Tap-slice input, publish handshake and published weight bus
//               between the array controller and the weight tap loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_tap_loader_if #(
    parameter int num_pe_col       = 16,
    parameter int nb_taps          = 11,
    parameter int weight_width     = 16,
    parameter int ETC_width        = 4,
    parameter int weight_bpr_width = ((weight_width + 1) / 2) * 3
);
    logic                                                    in_valid;
    logic                                                    in_ready;
    logic [num_pe_col-1:0][weight_width-1:0]                 in_wreg;
    logic [num_pe_col-1:0][weight_bpr_width-1:0]             in_wbpr;
    logic [num_pe_col-1:0][ETC_width-1:0]                    in_wetc;
    logic                                                    flush;
    logic                                                    commit;
    logic                                                    commit_ack;
    logic                                                    staged_full;
    logic                                                    out_valid;
    logic [num_pe_col-1:0][weight_width*nb_taps-1:0]         WRegs_fr_wbuff;
    logic [num_pe_col-1:0][weight_bpr_width*nb_taps-1:0]     WBPRs_fr_wbuff;
    logic [num_pe_col-1:0][ETC_width*nb_taps-1:0]            WETCs_fr_wbuff;

    modport master (
        output in_valid, in_wreg, in_wbpr, in_wetc, flush, commit,
        input  in_ready, commit_ack, staged_full, out_valid,
               WRegs_fr_wbuff, WBPRs_fr_wbuff, WETCs_fr_wbuff
    );

    modport slave (
        input  in_valid, in_wreg, in_wbpr, in_wetc, flush, commit,
        output in_ready, commit_ack, staged_full, out_valid,
               WRegs_fr_wbuff, WBPRs_fr_wbuff, WETCs_fr_wbuff
    );
endinterface
`default_nettype wire

// File: rtl/weight_tap_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_tap_loader
// Description : Stages one nb_taps weight set slice by slice, then publishes
//               it atomically into double-buffered output registers on commit.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_tap_loader #(
    parameter int num_pe_col       = 16,
    parameter int nb_taps          = 11,
    parameter int weight_width     = 16,
    parameter int ETC_width        = 4,
    parameter int weight_bpr_width = ((weight_width + 1) / 2) * 3
) (
    input wire                  clk,
    input wire                  rst,
    weight_tap_loader_if.slave  bus
);
    localparam int c_cnt_w  = (nb_taps > 1) ? $clog2(nb_taps) : 1;
    localparam int c_w_bits = weight_width * nb_taps;
    localparam int c_b_bits = weight_bpr_width * nb_taps;
    localparam int c_e_bits = ETC_width * nb_taps;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(nb_taps - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_publish;
    logic               r_commit_ack;
    logic               r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Commit only counts once the set is complete; flush loses to commit in FULL.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            FILL: begin
                w_in_ready = ~bus.flush;
                w_accept   = bus.in_valid & w_in_ready;
                if (bus.flush) begin
                    w_cnt_nxt = '0;
                end else if (w_accept) begin
                    if (r_cnt == c_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                w_cnt_nxt = '0;
                if (bus.commit) begin
                    w_publish   = 1'b1;
                    w_state_nxt = FILL;
                end else if (bus.flush) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_ack <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_commit_ack <= w_publish;
            r_out_valid  <= r_out_valid | w_publish;
        end
    end

    generate
        for (genvar c = 0; c < num_pe_col; c++) begin : g_col
            logic [c_w_bits-1:0] r_stage_w;
            logic [c_b_bits-1:0] r_stage_b;
            logic [c_e_bits-1:0] r_stage_e;
            logic [c_w_bits-1:0] r_out_w;
            logic [c_b_bits-1:0] r_out_b;
            logic [c_e_bits-1:0] r_out_e;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage_w <= '0;
                    r_stage_b <= '0;
                    r_stage_e <= '0;
                    r_out_w   <= '0;
                    r_out_b   <= '0;
                    r_out_e   <= '0;
                end else begin
                    if (w_accept) begin
                        r_stage_w[int'(r_cnt)*weight_width +: weight_width]         <= bus.in_wreg[c];
                        r_stage_b[int'(r_cnt)*weight_bpr_width +: weight_bpr_width] <= bus.in_wbpr[c];
                        r_stage_e[int'(r_cnt)*ETC_width +: ETC_width]               <= bus.in_wetc[c];
                    end
                    // Outputs keep the previous set while staging refills.
                    if (w_publish) begin
                        r_out_w <= r_stage_w;
                        r_out_b <= r_stage_b;
                        r_out_e <= r_stage_e;
                    end
                end
            end

            assign bus.WRegs_fr_wbuff[c] = r_out_w;
            assign bus.WBPRs_fr_wbuff[c] = r_out_b;
            assign bus.WETCs_fr_wbuff[c] = r_out_e;
        end
    endgenerate

    assign bus.in_ready    = w_in_ready;
    assign bus.staged_full = (r_state == FULL);
    assign bus.commit_ack  = r_commit_ack;
    assign bus.out_valid   = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_weight_tap_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_tap_loader
// Description : Directed scenarios plus random traffic against a tap-array
//               reference model of the weight tap loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_tap_loader;
    localparam int c_nc = 16;
    localparam int c_nt = 11;
    localparam int c_ww = 16;
    localparam int c_ew = 4;
    localparam int c_bw = ((c_ww + 1) / 2) * 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    weight_tap_loader_if #(
        .num_pe_col(c_nc), .nb_taps(c_nt), .weight_width(c_ww),
        .ETC_width(c_ew), .weight_bpr_width(c_bw)
    ) bus ();

    weight_tap_loader #(
        .num_pe_col(c_nc), .nb_taps(c_nt), .weight_width(c_ww),
        .ETC_width(c_ew), .weight_bpr_width(c_bw)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: staged and published sets as plain tap arrays.
    logic [c_ww-1:0] m_stage_w [c_nc][c_nt];
    logic [c_bw-1:0] m_stage_b [c_nc][c_nt];
    logic [c_ew-1:0] m_stage_e [c_nc][c_nt];
    logic [c_ww-1:0] m_pub_w   [c_nc][c_nt];
    logic [c_bw-1:0] m_pub_b   [c_nc][c_nt];
    logic [c_ew-1:0] m_pub_e   [c_nc][c_nt];
    int              m_taps;
    bit              m_full;
    bit              m_ack;
    bit              m_ov;
    bit              m_known;

    logic [c_ww-1:0] d_w [c_nc];
    logic [c_bw-1:0] d_b [c_nc];
    logic [c_ew-1:0] d_e [c_nc];

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [c_nt*c_ww-1:0] ew;
        logic [c_nt*c_bw-1:0] eb;
        logic [c_nt*c_ew-1:0] ee;
        check("commit_ack", 264'(bus.commit_ack), 264'(m_ack));
        check("staged_full", 264'(bus.staged_full), 264'(m_full));
        check("out_valid", 264'(bus.out_valid), 264'(m_ov));
        for (int c = 0; c < c_nc; c++) begin
            for (int k = 0; k < c_nt; k++) begin
                ew[k*c_ww +: c_ww] = m_pub_w[c][k];
                eb[k*c_bw +: c_bw] = m_pub_b[c][k];
                ee[k*c_ew +: c_ew] = m_pub_e[c][k];
            end
            check($sformatf("wregs[%0d]", c), 264'(bus.WRegs_fr_wbuff[c]), 264'(ew));
            check($sformatf("wbprs[%0d]", c), 264'(bus.WBPRs_fr_wbuff[c]), 264'(eb));
            check($sformatf("wetcs[%0d]", c), 264'(bus.WETCs_fr_wbuff[c]), 264'(ee));
        end
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs.
    // wval < 0 selects random weight data, otherwise every column gets wval.
    task automatic step(input bit v, input bit fl, input bit cm, input bit r, input int wval);
        for (int c = 0; c < c_nc; c++) begin
            d_w[c] = (wval >= 0) ? c_ww'(wval) : c_ww'($urandom);
            d_b[c] = c_bw'($urandom);
            d_e[c] = c_ew'($urandom);
            bus.in_wreg[c] = d_w[c];
            bus.in_wbpr[c] = d_b[c];
            bus.in_wetc[c] = d_e[c];
        end
        bus.in_valid = v;
        bus.flush    = fl;
        bus.commit   = cm;
        rst          = r;
        #1;
        if (m_known)
            check("in_ready", 264'(bus.in_ready), 264'(!m_full && !fl));

        if (r) begin
            for (int c = 0; c < c_nc; c++)
                for (int k = 0; k < c_nt; k++) begin
                    m_stage_w[c][k] = '0; m_stage_b[c][k] = '0; m_stage_e[c][k] = '0;
                    m_pub_w[c][k]   = '0; m_pub_b[c][k]   = '0; m_pub_e[c][k]   = '0;
                end
            m_taps = 0; m_full = 0; m_ack = 0; m_ov = 0; m_known = 1;
        end else if (m_known) begin
            m_ack = 0;
            if (m_full) begin
                if (cm) begin
                    m_pub_w = m_stage_w;
                    m_pub_b = m_stage_b;
                    m_pub_e = m_stage_e;
                    m_ov    = 1;
                    m_ack   = 1;
                    m_full  = 0;
                    m_taps  = 0;
                end else if (fl) begin
                    m_full = 0;
                    m_taps = 0;
                end
            end else if (fl) begin
                m_taps = 0;
            end else if (v) begin
                for (int c = 0; c < c_nc; c++) begin
                    m_stage_w[c][m_taps] = d_w[c];
                    m_stage_b[c][m_taps] = d_b[c];
                    m_stage_e[c][m_taps] = d_e[c];
                end
                m_taps++;
                if (m_taps == c_nt) begin
                    m_taps = 0;
                    m_full = 1;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        if (m_known) check_outputs();
    endtask

    task automatic feed(input int n, input int base);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, (base >= 0) ? base + k : -1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_known  = 0;
        rst      = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.commit   = 1'b0;
        bus.in_wreg  = '0;
        bus.in_wbpr  = '0;
        bus.in_wetc  = '0;

        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Back-to-back set 0x01xx, then commit.
        feed(c_nt, 'h100);
        step(0, 0, 1, 0, 0);
        check("set1_c0_tap0", 264'(bus.WRegs_fr_wbuff[0][15:0]), 264'(16'h0100));
        check("set1_c15_tap10", 264'(bus.WRegs_fr_wbuff[15][175:160]), 264'(16'h010A));

        // Commit held across the final acceptance is ignored until FULL.
        feed(c_nt - 1, 'h300);
        step(1, 0, 1, 0, 'h30A);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Second set replaces the first only on its commit.
        feed(c_nt, 'h200);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("set2_c3_tap4", 264'(bus.WRegs_fr_wbuff[3][79:64]), 264'(16'h0204));

        // Partial fill then flush, fresh set, commit.
        feed(5, 'h400);
        step(1, 1, 0, 0, 'h4FF);
        feed(c_nt, 'h500);
        step(0, 0, 1, 0, 0);

        // flush and commit together in FULL: commit wins.
        feed(c_nt, 'h600);
        step(0, 1, 1, 0, 0);

        // flush alone in FULL discards the set.
        feed(c_nt, 'h700);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);

        // Reset mid-fill, then a full set publishes cleanly.
        feed(7, 'h800);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        feed(c_nt, 'h900);
        step(0, 0, 1, 0, 0);

        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/weight_tap_loader.md
WEIGHT_TAP_LOADER -- requirements
Module: weight_tap_loader

Interface
REQ-001 Parameter num_pe_col, 16, number of PE columns fed.
REQ-002 Parameter nb_taps, 11, taps per column per weight set.
REQ-003 Parameter weight_width, 16, bits per weight tap.
REQ-004 Parameter ETC_width, 4, bits per ETC tap.
REQ-005 Parameter weight_bpr_width, ((weight_width+1)/2)*3, bits per BPR tap.
REQ-006 Single clock: clk input 1, all logic on rising edge.
REQ-007 Reset: rst input 1; synchronous, active-high.
REQ-008 in_valid  input  1  the tap slice on in_* is valid.
REQ-009 in_ready  output  1  the loader accepts a tap slice this cycle.
REQ-010 in_wreg  input  [num_pe_col][weight_width]  one weight tap for every column.
REQ-011 in_wbpr  input  [num_pe_col][weight_bpr_width]  one BPR tap for every column.
REQ-012 in_wetc  input  [num_pe_col][ETC_width]  one ETC tap for every column.
REQ-013 flush  input  1  abandon the partially staged set.
REQ-014 commit  input  1  request from the array controller to publish the staged set.
REQ-015 commit_ack  output  1  one-cycle pulse; the publish happened.
REQ-016 staged_full  output  1  the staging holds a complete nb_taps set.
REQ-017 out_valid  output  1  the WRegs/WBPRs/WETCs outputs hold a published set.
REQ-018 WRegs_fr_wbuff  output  [num_pe_col][weight_width*nb_taps]  published weights, registered.
REQ-019 WBPRs_fr_wbuff  output  [num_pe_col][weight_bpr_width*nb_taps]  published BPRs, registered.
REQ-020 WETCs_fr_wbuff  output  [num_pe_col][ETC_width*nb_taps]  published ETCs, registered.

Function
REQ-021 Two states, FILL and FULL; in_ready = (state==FILL) and not flush.
REQ-022 A tap counter runs 0..nb_taps-1; a slice is accepted when in_valid and in_ready are both high.
REQ-023 Accepted tap k goes into staging field [k*width +: width] for every column and every stream; then k increments.
REQ-024 On acceptance with k==nb_taps-1, the counter wraps to 0, the state goes to FULL and staged_full rises next cycle.
REQ-025 In FULL, in_ready=0 and the staging contents are frozen.
REQ-026 In FULL with commit=1, the next edge copies staging into all three output registers.
REQ-027 That same edge sets out_valid=1, pulses commit_ack=1 for one cycle, and returns the state to FILL with the counter at 0.
REQ-028 commit in FILL, including the cycle that accepts the final tap, is ignored: no copy and commit_ack stays 0.
REQ-029 Output registers change only on a commit edge; they hold the last published set while the next set fills (double buffering).
REQ-030 Once set, out_valid stays 1 until rst.
REQ-031 flush=1 in FILL sets the counter to 0 next edge; staging data need not be cleared, and no slice is accepted that cycle.
REQ-032 flush=1 in FULL returns the state to FILL with the counter at 0; the staged set is discarded.
REQ-033 flush and commit both high in FULL: commit wins and the set is published; flush is ignored.
REQ-034 Staging field positions not yet written are don't-care internally; only published fields are observable.
REQ-035 Latency is commit edge -> outputs valid in the same edge's registered value, i.e. one cycle after commit is sampled.

Reset
REQ-036 rst=1 at a clock edge forces state FILL, counter 0, staged_full=0, out_valid=0 and commit_ack=0.
REQ-037 rst=1 at a clock edge forces all output registers and staging to 0.
REQ-038 rst mid-fill or mid-commit discards everything; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-039 Feed 11 slices back-to-back, tap k = 16'h0100+k in every column; then pulse commit -> next cycle commit_ack=1, out_valid=1, and WRegs_fr_wbuff[c][k*16+:16]=16'h0100+k for all c,k.
REQ-040 Hold commit high while the 11th slice is accepted -> commit_ack=0 that edge; staged_full=1 next cycle; commit_ack=1 one cycle later; in_ready=0 in between.
REQ-041 After one published set, feed a second set with values 16'h0200+k -> outputs stay at the 0x01xx values until the second commit, then change to 0x02xx.
REQ-042 Accept 5 slices, assert flush for one cycle, then feed 11 new slices and commit -> outputs show only the new set; the counter restarts at 0.
REQ-043 In FULL, drive flush and commit together -> set published, commit_ack=1, state returns to FILL.
REQ-044 Assert rst after 7 accepted slices -> out_valid=0, all outputs 0, staged_full=0; a full set after release publishes correctly.
